gate_response_checker: RTL and testbench
========================================

GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, setting the width of all counters, the vector count and the index fields.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, the reset; reset is asynchronous and active-high.
REQ-004 The module SHALL have port start, input, 1, a request to begin a check run.
REQ-005 The module SHALL have port gate_sel, input, 3, the gate code under test: 0 NOT, 1 NAND, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
REQ-006 The module SHALL have port num_vec, input, CNT_W, the number of vectors in the run.
REQ-007 The module SHALL have port vec_valid, input, 1, meaning the current vec_a/vec_b/dut_out triple is a vector to check.
REQ-008 The module SHALL have ports vec_a and vec_b, input, 1 each, the stimulus applied to the DUT; NOT uses vec_a only.
REQ-009 The module SHALL have port dut_out, input, 1, the combinational DUT response to the current vec_a/vec_b.
REQ-010 The module SHALL have port busy, output, 1, high while a run is in progress.
REQ-011 The module SHALL have port done, output, 1, high once a run has completed.
REQ-012 The module SHALL have port pass, output, 1, the run verdict.
REQ-013 The module SHALL have ports vec_cnt and err_cnt, output, CNT_W each, the vectors checked and the mismatches found.
REQ-014 The module SHALL have ports first_fail_idx, output, CNT_W, and first_fail_valid, output, 1, giving the index of the first mismatch.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 On start in IDLE or DONE, the block SHALL latch gate_sel and num_vec, clear vec_cnt, err_cnt, first_fail_idx and first_fail_valid, and enter RUN on the next edge.
REQ-017 If the latched num_vec is 0 at start, the block SHALL go directly to DONE with pass=1.
REQ-018 start SHALL be ignored while in RUN.
REQ-019 In RUN, each cycle with vec_valid=1 SHALL compare dut_out against the expected value for the latched gate code, computed from the same-cycle vec_a/vec_b.
REQ-020 vec_cnt SHALL increment on the edge after each valid vector; cycles with vec_valid=0 SHALL leave all state unchanged.
REQ-021 On a mismatch, err_cnt SHALL increment, saturating at all-ones.
REQ-022 On the first mismatch, first_fail_idx SHALL capture the vec_cnt value before the increment and first_fail_valid SHALL set; later mismatches SHALL not change either.
REQ-023 Gate code 7 SHALL count every valid vector as a mismatch.
REQ-024 The valid vector for which vec_cnt reaches the latched num_vec SHALL move the FSM to DONE on that same edge; done SHALL rise one cycle after the final vector.
REQ-025 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE and SHALL hold until the next start or reset.
REQ-026 pass SHALL be (err_cnt==0) in DONE and 0 in IDLE and RUN.
REQ-027 vec_valid in IDLE or DONE SHALL be ignored.

Reset
REQ-028 While rst=1, the FSM SHALL be in IDLE with busy, done, pass, first_fail_valid = 0 and vec_cnt, err_cnt, first_fail_idx = 0.
REQ-029 Reset asserted mid-run SHALL abort the run immediately, with no done pulse.

Structure
REQ-030 The gate code constants (NOT..XNOR, reserved) and the FSM state encoding SHALL live in a shared package used by this block and the gate benches.
REQ-031 Expected-value computation SHALL be a combinational sub-module gate_ref_model (inputs gate_sel, a, b; output expected).

Verification
REQ-032 NOT, num_vec=4, in toggling 0,1,0,1, dut_out correct -> done after the 4th vector, vec_cnt=4, err_cnt=0, pass=1.
REQ-033 NAND, num_vec=4, all 4 input combinations, dut_out forced 1 on (1,1) -> err_cnt=1, first_fail_idx=3, pass=0.
REQ-034 XOR, num_vec=6, vec_valid gapped every other cycle -> vec_cnt=6 only after 6 valid cycles; busy=1 throughout.
REQ-035 num_vec=0 start -> DONE next cycle with pass=1 and vec_cnt=0; start pulsed in RUN -> ignored; restart from DONE -> counters cleared.
REQ-036 rst asserted after 2 of 5 vectors -> all outputs 0 asynchronously and state IDLE; gate_sel=7 run of 3 vectors -> err_cnt=3, first_fail_idx=0.
REQ-037 CNT_W=2, num_vec=3, every vector mismatched -> err_cnt saturates at 3, pass=0.

Source files
------------

// File: rtl/gate_response_checker_pkg.sv
// Shared definitions for the gate response checker and the gate benches.
// Contents:
//   GATE_* : gate codes carried on gate_sel
//   state_e: checker FSM state encoding
package gate_response_checker_pkg;

  localparam logic [2:0] GATE_NOT  = 3'd0;
  localparam logic [2:0] GATE_NAND = 3'd1;
  localparam logic [2:0] GATE_AND  = 3'd2;
  localparam logic [2:0] GATE_OR   = 3'd3;
  localparam logic [2:0] GATE_NOR  = 3'd4;
  localparam logic [2:0] GATE_XOR  = 3'd5;
  localparam logic [2:0] GATE_XNOR = 3'd6;
  localparam logic [2:0] GATE_RSVD = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gate_response_checker_ref_model.sv
// Combinational reference for the gate under test.
// Ports:
//   gate_sel : gate code (see gate_response_checker_pkg)
//   a, b     : stimulus bits (NOT uses a only)
//   expected : correct gate output; 0 for the reserved code, which the
//              checker treats as an unconditional mismatch anyway
module gate_ref_model
  import gate_response_checker_pkg::*;
(
  input  logic [2:0] gate_sel,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  always_comb begin
    expected = 1'b0;
    case (gate_sel)
      GATE_NOT:  expected = ~a;
      GATE_NAND: expected = ~(a & b);
      GATE_AND:  expected = a & b;
      GATE_OR:   expected = a | b;
      GATE_NOR:  expected = ~(a | b);
      GATE_XOR:  expected = a ^ b;
      GATE_XNOR: expected = ~(a ^ b);
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_response_checker.sv
// Checks a stream of responses from a single logic gate against the
// reference truth table and reports a pass/fail verdict for the run.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a run (ignored while a run is in progress)
//   gate_sel, num_vec : gate code and vector count, latched at start
//   vec_valid         : vec_a/vec_b/dut_out hold a vector to check
//   vec_a, vec_b      : stimulus applied to the gate
//   dut_out           : gate response to vec_a/vec_b
//   busy, done, pass  : run status and verdict
//   vec_cnt, err_cnt  : vectors checked, mismatches found (saturating)
//   first_fail_idx/_valid : index of the first mismatching vector
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             vec_valid,
  input  logic             vec_a,
  input  logic             vec_b,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_valid
);

  state_e           state;
  state_e           state_nxt;
  logic [2:0]       gate_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             expected;
  logic             mismatch;
  logic             start_ok;
  logic             vec_fire;

  gate_ref_model u_ref (
    .gate_sel (gate_q),
    .a        (vec_a),
    .b        (vec_b),
    .expected (expected)
  );

  // The reserved code has no defined truth table, so every vector fails.
  assign mismatch = (gate_q == GATE_RSVD) || (dut_out != expected);
  assign start_ok = start && (state != RUN);
  assign vec_fire = (state == RUN) && vec_valid;
  assign cnt_inc  = vec_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // An empty run skips RUN entirely; otherwise the last valid vector
  // moves to DONE on the same edge that counts it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (num_vec == '0) ? DONE : RUN;
      end
      RUN: begin
        if (vec_valid && (cnt_inc == num_q)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_q           <= GATE_NOT;
      num_q            <= '0;
      vec_cnt          <= '0;
      err_cnt          <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else if (start_ok) begin
      gate_q           <= gate_sel;
      num_q            <= num_vec;
      vec_cnt          <= '0;
      err_cnt          <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else if (vec_fire) begin
      vec_cnt <= cnt_inc;
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        // Index is the count before this vector, i.e. zero-based.
        if (!first_fail_valid) begin
          first_fail_idx   <= vec_cnt;
          first_fail_valid <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_cnt == '0);

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench for gate_response_checker: directed scenarios, then
// randomized runs compared against a behavioural model of a check run.
module tb_gate_response_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic       start2;
  logic [2:0] gate_sel;
  logic [7:0] num_vec;
  logic [1:0] num_vec2;
  logic       vec_valid;
  logic       vec_a;
  logic       vec_b;
  logic       dut_out;
  logic       busy, done, pass, first_fail_valid;
  logic [7:0] vec_cnt, err_cnt, first_fail_idx;
  logic       busy2, done2, pass2, first_fail_valid2;
  logic [1:0] vec_cnt2, err_cnt2, first_fail_idx2;

  int checks = 0;
  int errors = 0;

  // Behavioural model of one run
  bit m_run, m_done, m_ffv;
  int m_gate, m_num, m_cnt, m_err, m_ffi;

  gate_response_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
    .num_vec(num_vec), .vec_valid(vec_valid), .vec_a(vec_a), .vec_b(vec_b),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_fail_idx(first_fail_idx),
    .first_fail_valid(first_fail_valid)
  );

  gate_response_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .gate_sel(gate_sel),
    .num_vec(num_vec2), .vec_valid(vec_valid), .vec_a(vec_a), .vec_b(vec_b),
    .dut_out(dut_out), .busy(busy2), .done(done2), .pass(pass2),
    .vec_cnt(vec_cnt2), .err_cnt(err_cnt2), .first_fail_idx(first_fail_idx2),
    .first_fail_valid(first_fail_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic bit goldenOut(int g, bit a, bit b);
    case (g)
      0: return !a;
      1: return !(a && b);
      2: return a && b;
      3: return a || b;
      4: return !(a || b);
      5: return a != b;
      6: return a == b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    m_run = 0; m_done = 0; m_ffv = 0;
    m_cnt = 0; m_err = 0; m_ffi = 0;
  endtask

  task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    checkValue({tag, ".busy"}, 32'(busy), 32'(m_run));
    checkValue({tag, ".done"}, 32'(done), 32'(m_done));
    checkValue({tag, ".pass"}, 32'(pass), 32'(m_done && (m_err == 0)));
    checkValue({tag, ".vec_cnt"}, 32'(vec_cnt), 32'(m_cnt));
    checkValue({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
    checkValue({tag, ".ffi"}, 32'(first_fail_idx), 32'(m_ffi));
    checkValue({tag, ".ffv"}, 32'(first_fail_valid), 32'(m_ffv));
  endtask

  // Drive one cycle of inputs, clock it, and advance the model to match.
  task automatic applyStimulus(bit st, int g, int n, bit v, bit a, bit b, bit o);
    start = st; gate_sel = 3'(g); num_vec = 8'(n);
    vec_valid = v; vec_a = a; vec_b = b; dut_out = o;
    @(posedge clk);
    #1;
    if (!m_run) begin
      if (st) begin
        m_gate = g; m_num = n;
        m_cnt = 0; m_err = 0; m_ffi = 0; m_ffv = 0;
        m_run = (n != 0);
        m_done = (n == 0);
      end
    end else if (v) begin
      if (m_gate == 7 || o != goldenOut(m_gate, a, b)) begin
        if (!m_ffv) begin m_ffi = m_cnt; m_ffv = 1; end
        if (m_err < 255) m_err++;
      end
      m_cnt++;
      if (m_cnt == m_num) begin m_run = 0; m_done = 1; end
    end
    start = 0;
  endtask

  initial begin
    bit a, b, o, v, st;
    int g, n, guard;
    start = 0; start2 = 0; gate_sel = 0; num_vec = 0; num_vec2 = 0;
    vec_valid = 0; vec_a = 0; vec_b = 0; dut_out = 0;

    // Reset takes effect without a clock edge
    rst = 1;
    #1;
    modelReset();
    checkOutput("reset_async");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    checkOutput("reset_idle");

    // vec_valid in IDLE is ignored
    applyStimulus(0, 2, 4, 1, 1, 1, 0);
    checkOutput("idle_ignore");

    // NOT, four toggling vectors, all correct
    applyStimulus(1, 0, 4, 0, 0, 0, 0);
    checkOutput("not_start");
    for (int i = 0; i < 4; i++) begin
      a = bit'(i % 2);
      applyStimulus(0, 0, 4, 1, a, 0, !a);
      checkOutput("not_vec");
    end
    checkValue("not_done", 32'(done), 32'd1);
    checkValue("not_pass", 32'(pass), 32'd1);

    // NAND, all combinations, response wrong on (1,1)
    applyStimulus(1, 1, 4, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      a = bit'(i / 2); b = bit'(i % 2);
      applyStimulus(0, 1, 4, 1, a, b, 1'b1);
      checkOutput("nand_vec");
    end
    checkValue("nand_ffi", 32'(first_fail_idx), 32'd3);
    checkValue("nand_err", 32'(err_cnt), 32'd1);

    // XOR, six vectors with a gap after each
    applyStimulus(1, 5, 6, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      a = bit'($urandom_range(0, 1)); b = bit'($urandom_range(0, 1));
      applyStimulus(0, 5, 6, bit'(i % 2 == 0), a, b, a ^ b);
      checkOutput("xor_gap");
    end

    // Empty run goes straight to DONE
    applyStimulus(1, 2, 0, 0, 0, 0, 0);
    checkOutput("empty_run");
    checkValue("empty_done", 32'(done), 32'd1);

    // start while running is ignored; restart from DONE clears counters
    applyStimulus(1, 2, 3, 0, 0, 0, 0);
    applyStimulus(0, 2, 3, 1, 1, 1, 0);
    applyStimulus(1, 2, 0, 1, 1, 0, 0);
    checkOutput("start_in_run");
    applyStimulus(0, 2, 3, 1, 1, 1, 1);
    checkOutput("run_end");
    applyStimulus(1, 3, 2, 0, 0, 0, 0);
    checkOutput("restart_clear");

    // Reset mid-run aborts immediately
    applyStimulus(1, 3, 5, 0, 0, 0, 0);
    applyStimulus(0, 3, 5, 1, 1, 0, 1);
    applyStimulus(0, 3, 5, 1, 0, 0, 1);
    checkOutput("pre_abort");
    #2;
    rst = 1;
    #1;
    modelReset();
    checkOutput("abort_async");
    @(posedge clk); #1;
    rst = 0;
    applyStimulus(0, 3, 5, 1, 0, 0, 0);
    checkOutput("abort_no_done");

    // Reserved code fails every vector
    applyStimulus(1, 7, 3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 7, 3, 1, bit'(i % 2), 1, bit'(i % 2));
      checkOutput("rsvd_vec");
    end
    checkValue("rsvd_err", 32'(err_cnt), 32'd3);

    // Narrow counters: every vector wrong, error count pinned at all-ones
    start2 = 1; num_vec2 = 2'd3;
    applyStimulus(0, 2, 0, 0, 0, 0, 0);
    start2 = 0;
    checkValue("w2_busy", 32'(busy2), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 2, 0, 1, 1, 1, 0);
    checkValue("w2_done", 32'(done2), 32'd1);
    checkValue("w2_err", 32'(err_cnt2), 32'd3);
    checkValue("w2_cnt", 32'(vec_cnt2), 32'd3);
    checkValue("w2_pass", 32'(pass2), 32'd0);
    checkValue("w2_ffi", 32'(first_fail_idx2), 32'd0);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      g = int'($urandom_range(0, 7));
      n = int'($urandom_range(0, 12));
      applyStimulus(1, g, n, 0, 0, 0, 0);
      checkOutput("rnd_start");
      guard = 0;
      while (m_run && guard < 200) begin
        v = bit'($urandom_range(0, 1));
        a = bit'($urandom_range(0, 1));
        b = bit'($urandom_range(0, 1));
        o = goldenOut(g, a, b) ^ ($urandom_range(0, 3) == 0);
        st = ($urandom_range(0, 7) == 0);
        applyStimulus(st, int'($urandom_range(0, 7)), 0, v, a, b, o);
        checkOutput("rnd_vec");
        guard++;
      end
      applyStimulus(0, 0, 0, 1, 1, 1, 1);
      checkOutput("rnd_after");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
